// File: rtl/mio_pkg.sv
// Shared types and constants for the CPU memory/IO bus unit:
// FSM state encoding, address regions and their top-nibble codes.
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_GPIO = 2'd1,
    REG_CNT  = 2'd2,
    REG_NONE = 2'd3
  } region_t;

  localparam logic [3:0]  NIB_RAM  = 4'h0;
  localparam logic [3:0]  NIB_GPIO = 4'hF;
  localparam logic [3:0]  NIB_CNT  = 4'hE;

  localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational region decode from the top nibble of the CPU byte address.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [3:0] addr_hi,
  output region_t    region
);

  always_comb begin
    region = REG_NONE;
    case (addr_hi)
      NIB_RAM:  region = REG_RAM;
      NIB_GPIO: region = REG_GPIO;
      NIB_CNT:  region = REG_CNT;
      default:  region = REG_NONE;
    endcase
  end

endmodule

// File: rtl/mio_bus.sv
// Memory/IO bus unit: latches a CPU request, sequences RAM wait states and
// returns a one-cycle MIO_ready. Optional error capture under MIO_BUS_ERR_EN.
module mio_bus
  import mio_pkg::*;
#(
  parameter int RAM_WAIT = 2,
  parameter int RAM_AW   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              CPU_MIO,
  input  logic [31:0]       addr_bus,
  input  logic [31:0]       cpu_data_out,
  output logic [31:0]       cpu_data_in,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  output logic              gpio_we,
  output logic [31:0]       gpio_dout,
  input  logic [15:0]       sw_in,
  output logic              counter_we,
  input  logic [31:0]       counter_out
`ifdef MIO_BUS_ERR_EN
  ,
  output logic              bus_err,
  output logic [31:0]       err_addr
`endif
);

  localparam logic [2:0] WAIT_INIT = 3'(RAM_WAIT);

  state_t     state_reg, state_next;
  region_t    region_dec, region_reg;
  logic [2:0] cnt_reg;
  logic       wr_reg;
  logic       request, latch, complete;
  logic       unused_addr_bits;

  mio_addr_decode u_decode (
    .addr_hi (addr_bus[31:28]),
    .region  (region_dec)
  );

  assign request = CPU_MIO & (MemRead ^ MemWrite);
  assign latch   = (state_reg == ST_IDLE) & request;
  // Word accesses only: byte-lane bits and the gap above the RAM index are don't-care.
  assign unused_addr_bits = ^{addr_bus[27:RAM_AW+2], addr_bus[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    complete   = 1'b0;
    ram_we     = 1'b0;
    gpio_we    = 1'b0;
    counter_we = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (request) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_reg == 3'd0) begin
          complete   = 1'b1;
          state_next = ST_DONE;
          ram_we     = wr_reg & (region_reg == REG_RAM);
          gpio_we    = wr_reg & (region_reg == REG_GPIO);
          counter_we = wr_reg & (region_reg == REG_CNT);
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg     <= 3'd0;
      wr_reg      <= 1'b0;
      region_reg  <= REG_NONE;
      MIO_ready   <= 1'b0;
      cpu_data_in <= 32'h0;
      ram_addr    <= '0;
      ram_din     <= 32'h0;
      gpio_dout   <= 32'h0;
    end else begin
      MIO_ready <= complete;
      if (latch) begin
        wr_reg     <= MemWrite;
        region_reg <= region_dec;
        cnt_reg    <= (region_dec == REG_RAM) ? WAIT_INIT : 3'd0;
        if (region_dec == REG_RAM) begin
          ram_addr <= addr_bus[RAM_AW+1:2];
          if (MemWrite) ram_din <= cpu_data_out;
        end
        // gpio_dout doubles as the peripheral write bus for the counter load.
        if (MemWrite && (region_dec == REG_GPIO || region_dec == REG_CNT))
          gpio_dout <= cpu_data_out;
      end else if (state_reg == ST_ACCESS && cnt_reg != 3'd0) begin
        cnt_reg <= cnt_reg - 3'd1;
      end
      if (complete && !wr_reg) begin
        case (region_reg)
          REG_RAM:  cpu_data_in <= ram_dout;
          REG_GPIO: cpu_data_in <= {16'h0000, sw_in};
          REG_CNT:  cpu_data_in <= counter_out;
          default:  cpu_data_in <= UNMAPPED_RDATA;
        endcase
      end
    end
  end

`ifdef MIO_BUS_ERR_EN
  logic [31:0] addr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg <= 32'h0;
      bus_err  <= 1'b0;
      err_addr <= 32'h0;
    end else begin
      if (latch) addr_reg <= addr_bus;
      // Only the first error is recorded; bus_err is sticky until reset.
      if (!bus_err) begin
        if (state_reg == ST_IDLE && CPU_MIO && MemRead && MemWrite) begin
          bus_err  <= 1'b1;
          err_addr <= addr_bus;
        end else if (complete && region_reg == REG_NONE) begin
          bus_err  <= 1'b1;
          err_addr <= addr_reg;
        end
      end
    end
  end
`endif

endmodule
